// File: rtl/spare_remap_allocator.sv
// Spare-column allocator: scans a fault mask SCAN_WIDTH columns per cycle,
// assigns faulty columns to spares in ascending order and serves a registered lookup.
module spare_remap_allocator #(
    parameter int NUM_COLS   = 256,
    parameter int NUM_SPARES = 8,
    parameter int SCAN_WIDTH = 4,
    localparam int CW  = $clog2(NUM_COLS),
    localparam int SW  = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
    localparam int NW  = $clog2(NUM_SPARES + 1),
    localparam int NCH = NUM_COLS / SCAN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       append,
    input  logic [NUM_COLS-1:0]        fault_mask,
    output logic                       busy,
    output logic                       done,
    output logic                       repair_fail,
    output logic [NW-1:0]              spare_used_count,
    output logic [NUM_SPARES*CW-1:0]   remap_flat,
    output logic [NUM_SPARES-1:0]      remap_valid,
    input  logic [CW-1:0]              lookup_col,
    output logic                       lookup_hit,
    output logic [SW-1:0]              lookup_spare
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [NUM_COLS-1:0]        r_pending;
    logic [NUM_COLS-1:0]        r_mapped;
    logic [PW-1:0]              r_chunk_ptr;
    logic [NW-1:0]              r_count;
    logic [NUM_SPARES-1:0]      r_valid;
    logic [NUM_SPARES*CW-1:0]   r_flat;
    logic                       r_done;
    logic                       r_fail;
    logic                       r_hit;
    logic [SW-1:0]              r_spare;

    logic [CW-1:0]              w_base;
    logic [SCAN_WIDTH-1:0]      w_chunk;
    logic [SCAN_WIDTH-1:0]      w_low_oh;
    logic [LW-1:0]              w_low_idx;
    logic [CW-1:0]              w_col;
    logic                       w_rest;
    logic                       w_last;
    logic                       w_full;
    logic                       w_start_ok;
    logic                       w_alloc;
    logic                       w_fail_now;
    logic                       w_advance;
    logic                       w_finish;
    logic [NUM_COLS-1:0]        w_mapped_next;
    logic                       w_hit;
    logic [SW-1:0]              w_spare;

    assign w_base  = CW'(r_chunk_ptr) * CW'(SCAN_WIDTH);
    assign w_chunk = r_pending[w_base +: SCAN_WIDTH];

    // Lowest faulty column of the current chunk wins this cycle.
    always_comb begin
        w_low_idx = '0;
        w_low_oh  = '0;
        for (int i = SCAN_WIDTH - 1; i >= 0; i--) begin
            if (w_chunk[i]) begin
                w_low_idx   = LW'(i);
                w_low_oh    = '0;
                w_low_oh[i] = 1'b1;
            end
        end
    end

    assign w_col         = w_base + CW'(w_low_idx);
    assign w_rest        = |(w_chunk & ~w_low_oh);
    assign w_last        = (r_chunk_ptr == PW'(NCH - 1));
    assign w_full        = (r_count == NW'(NUM_SPARES));
    assign w_mapped_next = append ? r_mapped : '0;

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_alloc      = 1'b0;
        w_fail_now   = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_chunk == '0) begin
                    w_advance = !w_last;
                    w_finish  = w_last;
                end else if (w_full) begin
                    w_fail_now = 1'b1;
                    w_finish   = 1'b1;
                end else begin
                    w_alloc   = 1'b1;
                    w_advance = !w_rest && !w_last;
                    w_finish  = !w_rest && w_last;
                end
                if (w_finish) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lowest matching spare index wins if a column somehow appears twice.
    always_comb begin
        w_hit   = 1'b0;
        w_spare = '0;
        for (int i = NUM_SPARES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_flat[i*CW +: CW] == lookup_col)) begin
                w_hit   = 1'b1;
                w_spare = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_mapped    <= '0;
            r_chunk_ptr <= '0;
            r_count     <= '0;
            r_valid     <= '0;
            r_flat      <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_hit       <= 1'b0;
            r_spare     <= '0;
        end else begin
            r_done  <= w_finish;
            r_hit   <= w_hit;
            r_spare <= w_spare;
            if (w_start_ok) begin
                if (!append) begin
                    r_valid <= '0;
                    r_count <= '0;
                end
                r_mapped    <= w_mapped_next;
                r_pending   <= fault_mask & ~w_mapped_next;
                r_fail      <= 1'b0;
                r_chunk_ptr <= '0;
            end else begin
                if (w_alloc) begin
                    for (int i = 0; i < NUM_SPARES; i++) begin
                        if (NW'(i) == r_count) begin
                            r_flat[i*CW +: CW] <= w_col;
                            r_valid[i]         <= 1'b1;
                        end
                    end
                    r_mapped[w_col]  <= 1'b1;
                    r_pending[w_col] <= 1'b0;
                    r_count          <= r_count + NW'(1);
                end
                if (w_advance) begin
                    r_chunk_ptr <= r_chunk_ptr + PW'(1);
                end
                if (w_fail_now) begin
                    r_fail <= 1'b1;
                end
            end
        end
    end

    assign busy             = (r_state == S_SCAN);
    assign done             = r_done;
    assign repair_fail      = r_fail;
    assign spare_used_count = r_count;
    assign remap_flat       = r_flat;
    assign remap_valid      = r_valid;
    assign lookup_hit       = r_hit;
    assign lookup_spare     = r_spare;

endmodule

// File: tb/tb_spare_remap_allocator.sv
// Table-driven bench for spare_remap_allocator (16 columns, 4 spares, 4-wide scan)
// with a scoreboard queue of expected pass results.
module tb_spare_remap_allocator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        append;
    logic [15:0] fault_mask;
    logic        busy;
    logic        done;
    logic        repair_fail;
    logic [2:0]  spare_used_count;
    logic [15:0] remap_flat;
    logic [3:0]  remap_valid;
    logic [3:0]  lookup_col;
    logic        lookup_hit;
    logic [1:0]  lookup_spare;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        app;
        logic [15:0] mask;
        int          cyc;
        int          cnt;
        logic [3:0]  vld;
        logic [15:0] ent;
        logic        fail;
        logic [3:0]  lk_col;
        logic        lk_hit;
        logic [1:0]  lk_spare;
    } vec_t;

    vec_t vecs[9];
    vec_t q_exp[$];

    spare_remap_allocator #(
        .NUM_COLS   (16),
        .NUM_SPARES (4),
        .SCAN_WIDTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .append           (append),
        .fault_mask       (fault_mask),
        .busy             (busy),
        .done             (done),
        .repair_fail      (repair_fail),
        .spare_used_count (spare_used_count),
        .remap_flat       (remap_flat),
        .remap_valid      (remap_valid),
        .lookup_col       (lookup_col),
        .lookup_hit       (lookup_hit),
        .lookup_spare     (lookup_spare)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Runs one pass; poke_at > 0 pulses a stray start on that busy cycle.
    task automatic run_vec(input vec_t v, input int poke_at, input string tag);
        vec_t e;
        int   cyc;
        @(posedge clk); #1;
        start      = 1'b1;
        append     = v.app;
        fault_mask = v.mask;
        q_exp.push_back(v);
        @(posedge clk); #1;
        start  = 1'b0;
        append = 1'b0;
        cyc    = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == poke_at) begin
                start      = 1'b1;
                fault_mask = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (cyc >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s timeout busy_cycles=%0d required=%0d", tag, cyc, v.cyc);
        end
        if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
            return;
        end
        e = q_exp.pop_front();
        chk({tag, " busy_cycles"}, cyc, e.cyc);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " count"}, spare_used_count, e.cnt);
        chk({tag, " valid"}, remap_valid, e.vld);
        chk({tag, " fail"}, repair_fail, e.fail);
        for (int i = 0; i < 4; i++) begin
            if (e.vld[i]) begin
                chk($sformatf("%s entry%0d", tag, i), remap_flat[i*4 +: 4], e.ent[i*4 +: 4]);
            end
        end
        lookup_col = e.lk_col;
        @(posedge clk); #1;
        chk({tag, " done_pulse_end"}, done, 1'b0);
        chk({tag, " busy_after"}, busy, 1'b0);
        chk({tag, " lk_hit"}, lookup_hit, e.lk_hit);
        chk({tag, " lk_spare"}, lookup_spare, e.lk_spare);
    endtask

    initial begin
        int   done_seen;
        vec_t v;

        //          app  mask      cyc cnt vld      ent       fail lk     hit  spare
        vecs[0] = '{1'b0, 16'h0000, 4, 0, 4'b0000, 16'h0000, 1'b0, 4'd0,  1'b0, 2'd0};
        vecs[1] = '{1'b0, 16'h0206, 5, 3, 4'b0111, 16'h0921, 1'b0, 4'd9,  1'b1, 2'd2};
        vecs[2] = '{1'b0, 16'h002F, 5, 4, 4'b1111, 16'h3210, 1'b1, 4'd3,  1'b1, 2'd3};
        vecs[3] = '{1'b0, 16'h000F, 7, 4, 4'b1111, 16'h3210, 1'b0, 4'd2,  1'b1, 2'd2};
        vecs[4] = '{1'b1, 16'h000F, 4, 4, 4'b1111, 16'h3210, 1'b0, 4'd0,  1'b1, 2'd0};
        vecs[5] = '{1'b1, 16'h0100, 3, 4, 4'b1111, 16'h3210, 1'b1, 4'd8,  1'b0, 2'd0};
        vecs[6] = '{1'b0, 16'h0010, 4, 1, 4'b0001, 16'h0004, 1'b0, 4'd4,  1'b1, 2'd0};
        vecs[7] = '{1'b1, 16'h1010, 4, 2, 4'b0011, 16'h00C4, 1'b0, 4'd12, 1'b1, 2'd1};
        vecs[8] = '{1'b0, 16'h0080, 4, 1, 4'b0001, 16'h0007, 1'b0, 4'd12, 1'b0, 2'd0};

        rst        = 1'b1;
        start      = 1'b0;
        append     = 1'b0;
        fault_mask = '0;
        lookup_col = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst fail", repair_fail, 1'b0);
        chk("rst count", spare_used_count, 3'd0);
        chk("rst valid", remap_valid, 4'd0);
        chk("rst flat", remap_flat, 16'd0);
        chk("rst lk_hit", lookup_hit, 1'b0);
        chk("rst lk_spare", lookup_spare, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Stray start mid-scan with an all-faults mask must be ignored.
        v = '{1'b0, 16'h0206, 5, 3, 4'b0111, 16'h0921, 1'b0, 4'd3, 1'b0, 2'd0};
        run_vec(v, 2, "busy_start");
        repeat (3) begin
            @(posedge clk); #1;
            chk("busy_start idle", busy, 1'b0);
        end

        // Reset in the middle of a scan after an allocation has landed.
        @(posedge clk); #1;
        start      = 1'b1;
        append     = 1'b0;
        fault_mask = 16'h0206;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("midrst pre busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst count", spare_used_count, 3'd0);
        chk("midrst valid", remap_valid, 4'd0);
        chk("midrst flat", remap_flat, 16'd0);
        chk("midrst lk_hit", lookup_hit, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("midrst no_done", done_seen, 0);

        v = '{1'b1, 16'h1000, 4, 1, 4'b0001, 16'h000C, 1'b0, 4'd1, 1'b0, 2'd0};
        run_vec(v, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spare_remap_allocator.md
# spare_remap_allocator

- Parametrised successor to the single-pass spare-row mapper.
- Scans a post-test fault mask SCAN_WIDTH columns per cycle and assigns faulty columns to spares in ascending column order.
- Supports incremental (append) repair passes that keep prior allocations. Flags repair failure on spare exhaustion.
- Provides a registered column-to-spare lookup port for the datapath mux controller.
- Sits between the BIST result collector and the array column-redirect logic.

## Interface
Parameters:
- NUM_COLS, 256, columns in the protected array; must be a multiple of SCAN_WIDTH.
- NUM_SPARES, 8, spare columns available; ≥1.
- SCAN_WIDTH, 4, columns examined per scan cycle; power of two, ≤ NUM_COLS.
- Derived: CW = clog2(NUM_COLS); SW = max(1, clog2(NUM_SPARES)); NW = clog2(NUM_SPARES+1); NCH = NUM_COLS/SCAN_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a repair pass; sampled only in IDLE.
- append  in  1  sampled with start: 0 = clear table first, 1 = keep existing allocations.
- fault_mask  in  NUM_COLS  1 = faulty column; snapshotted on accepted start.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse at end of pass.
- repair_fail  out  1  set when a fault cannot be given a spare; held until next accepted start.
- spare_used_count  out  NW  number of valid table entries.
- remap_flat  out  NUM_SPARES*CW  entry i at [i*CW +: CW] = column replaced by spare i.
- remap_valid  out  NUM_SPARES  entry i valid.
- lookup_col  in  CW  column to translate.
- lookup_hit  out  1  registered: lookup_col is mapped.
- lookup_spare  out  SW  registered: spare index for lookup_col; 0 when no hit.

## Operation
- State: IDLE, SCAN. Internal registers:
  - pending[NUM_COLS]: faults not yet handled.
  - mapped[NUM_COLS]: columns currently owning a spare.
  - chunk_ptr: clog2(NCH) bits, min 1.
- IDLE with start=1:
  - append=0: clear remap_valid, mapped, spare_used_count.
  - pending <= fault_mask & ~mapped_next, where mapped_next is the post-clear value.
  - Clear repair_fail; chunk_ptr <= 0; go to SCAN.
- SCAN, each cycle, with chunk = pending[chunk_ptr*SCAN_WIDTH +: SCAN_WIDTH]:
  - chunk == 0:
    - If chunk_ptr == NCH-1, go to IDLE and pulse done.
    - Else chunk_ptr++.
  - chunk != 0: take the lowest set bit as column c.
    - spare_used_count < NUM_SPARES:
      - Write entry[spare_used_count] = c and set its valid bit.
      - Set mapped[c], clear pending[c], increment the count.
      - If no other bit remains in the chunk, advance chunk_ptr the same cycle. On the last chunk, go to IDLE and pulse done.
    - spare_used_count == NUM_SPARES: set repair_fail, go to IDLE, pulse done. Remaining faults stay unrepaired; the table is unchanged.
- Scan cycle count C = Σ over chunks of max(1, faults in chunk), or fewer on failure.
- A column already mapped before an append pass is never re-allocated.
- A full table with no new faults is not a failure.
- start while busy is ignored. The append input is ignored except on an accepted start.
- Lookup:
  - Compare lookup_col against every valid entry.
  - On a match, lookup_hit <= 1 and lookup_spare <= lowest matching index. Otherwise both <= 0.
  - Operates in every state.

## Timing
- Reset (asynchronous) drives state IDLE and busy = done = repair_fail = 0.
- Reset also zeroes spare_used_count, remap_valid, remap_flat, pending, mapped, chunk_ptr, lookup_hit and lookup_spare.
- Reset mid-pass aborts the pass and clears all allocations; no done is produced.
- Start accepted at edge k:
  - busy = 1 from cycle k+1 through k+C.
  - done = 1 and busy = 0 in cycle k+1+C.
  - A new start is accepted on that same done edge.
- Table outputs and spare_used_count update on the edge of each allocation.
- Lookup latency is one cycle. It reflects the table as of the edge on which it samples, so allocations made on the same edge are not seen.

## Test plan
Bench parameters: NUM_COLS=16, NUM_SPARES=4, SCAN_WIDTH=4.
- **Clean array:** start with append=0, fault_mask=0 at edge 0 -> busy in cycles 1–4, done in cycle 5, count 0, remap_valid 0000, repair_fail 0.
- **Single-chunk faults:** faults at 1, 2, 9 -> entries {1, 2, 9} valid; C=5, so done in cycle 6.
  - Chunk 0 takes two cycles, allocating 1 and then 2.
  - Lookup of 9 gives hit=1, spare=2. Lookup of 3 gives hit=0.
- **Overflow:** faults at 0, 1, 2, 3, 5 -> spares 0–3 map columns 0–3.
  - The fault at 5 meets a full table -> repair_fail=1, done pulses, count=4.
  - A subsequent start clears repair_fail.
- **Append pass:** first pass with fault at 4, then append=1 with faults 4 and 12 -> column 4 kept on spare 0, column 12 placed on spare 1, count=2, no failure.
- **Append=0 clears prior work:** after the append case, start with append=0 and fault 7 -> only entry 0 valid, holding 7. Lookup of 12 gives hit=0.
- **Robustness:**
  - Assert start while busy -> no effect.
  - Assert rst mid-scan -> all outputs zero immediately, no done pulse.
  - Next start behaves as if from reset.
